// File: rtl/rf_pkg.sv
// Shared register-file constants: default data width, register count and
// the address-width helper used by every register-file instance in the core.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register-0 zeroing, write-to-read bypass,
// and masking of the scoreboard bit when the pending write lands this cycle.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int BYPASS = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic [AW-1:0]          rd_addr,
  input  logic [NREGS*XLEN-1:0]  regs_flat,
  input  logic [NREGS-1:0]       busy_vec,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  output logic [XLEN-1:0]        rd_data,
  output logic                   rd_busy
);

  logic hit;

  assign hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && (rd_addr != '0);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_addr != '0) begin
      rd_data = hit ? wr_data : regs_flat[int'(rd_addr)*XLEN +: XLEN];
      rd_busy = busy_vec[rd_addr] & ~hit;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file with a per-register pending-write scoreboard.
// Register 0 is hardwired to zero and never busy.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN   = RF_XLEN,
  parameter  int NREGS  = RF_NREGS,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = rf_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0]       regs [1:NREGS-1];
  logic [NREGS-1:1]      busy_q;
  logic [NREGS*XLEN-1:0] regs_flat;

  logic wr_ok;
  logic alloc_ok;

  assign wr_ok    = wr_en && (wr_addr != '0);
  assign alloc_ok = alloc_en && (alloc_addr != '0);

  // NOTE: the array is reset explicitly because a reset must make every
  // register read as zero immediately; this keeps it out of plain RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments make the later alloc set override the
  // earlier writeback clear when both name the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)    busy_q[wr_addr]    <= 1'b0;
      if (alloc_ok) busy_q[alloc_addr] <= 1'b1;
    end
  end

  assign busy_vec = {busy_q, 1'b0};

  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = regs[i];
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    rf_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rd (
      .rd_addr   (rd_addr[k*AW +: AW]),
      .regs_flat (regs_flat),
      .busy_vec  (busy_vec),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[k*XLEN +: XLEN]),
      .rd_busy   (rd_busy[k])
    );
  end

endmodule
